// File: rtl/ysyx_25040111_axi_slave_mem.sv
// AXI4 responder memory model: one transaction at a time, INCR/FIXED bursts, word-wide storage.
// Latency: first rvalid RD_LAT cycles after the AR handshake; writes land on each W handshake, B follows wlast.
// Backpressure: rready/bready stalls hold all R/B outputs stable; AW/AR/W are refused outside their FSM state.
//
// Ports:
//   clock, reset                 - clock and synchronous active-high reset
//   io_slave_aw* / io_slave_w*   - write address and write data channels (responder side)
//   io_slave_b*                  - write response channel, bresp is the worst response seen in the burst
//   io_slave_ar* / io_slave_r*   - read address and read data channels (responder side)
//
// The memory array is deliberately left unreset so simulation contents survive a core reset.

module ysyx_25040111_axi_slave_mem #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          RD_LAT     = 1
) (
    input  logic        clock,
    input  logic        reset,

    output logic        io_slave_awready,
    input  logic        io_slave_awvalid,
    input  logic [31:0] io_slave_awaddr,
    input  logic [3:0]  io_slave_awid,
    input  logic [7:0]  io_slave_awlen,
    input  logic [2:0]  io_slave_awsize,
    input  logic [1:0]  io_slave_awburst,

    output logic        io_slave_wready,
    input  logic        io_slave_wvalid,
    input  logic [31:0] io_slave_wdata,
    input  logic [3:0]  io_slave_wstrb,
    input  logic        io_slave_wlast,

    input  logic        io_slave_bready,
    output logic        io_slave_bvalid,
    output logic [1:0]  io_slave_bresp,
    output logic [3:0]  io_slave_bid,

    output logic        io_slave_arready,
    input  logic        io_slave_arvalid,
    input  logic [31:0] io_slave_araddr,
    input  logic [3:0]  io_slave_arid,
    input  logic [7:0]  io_slave_arlen,
    input  logic [2:0]  io_slave_arsize,
    input  logic [1:0]  io_slave_arburst,

    input  logic        io_slave_rready,
    output logic        io_slave_rvalid,
    output logic [1:0]  io_slave_rresp,
    output logic [31:0] io_slave_rdata,
    output logic        io_slave_rlast,
    output logic [3:0]  io_slave_rid
);

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    // One extra bit so the byte size never overflows the compare.
    localparam logic [32:0] MEM_BYTES = 33'd4 << DEPTH_LOG2;
    localparam int          LAT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      mem [0:DEPTH-1];

    logic [LAT_W-1:0] lat_cnt;
    logic [31:0]      cur_addr;
    logic [3:0]       cur_id;
    logic [7:0]       cur_len;
    logic [2:0]       cur_size;
    logic [1:0]       cur_burst;
    logic [7:0]       beat;
    logic [1:0]       err;

    logic [31:0]           off;
    logic                  in_range;
    logic                  bad_burst;
    logic                  access_ok;
    logic [1:0]            beat_resp;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [31:0]           next_addr;
    logic                  proto_err;
    logic [1:0]            w_resp;

    logic aw_hs, ar_hs, w_hs, r_hs, b_hs;

    // ------------------------------------------------------------------
    // Per-beat address decode, shared by read and write bursts
    // ------------------------------------------------------------------
    assign off       = cur_addr - ADDR_BASE;
    assign in_range  = {1'b0, off} < MEM_BYTES;
    assign bad_burst = cur_burst[1];
    assign access_ok = in_range && !bad_burst;
    assign word_idx  = off[DEPTH_LOG2+1:2];
    assign next_addr = (cur_burst == BURST_INCR) ? cur_addr + (32'd1 << cur_size) : cur_addr;

    always_comb begin
        beat_resp = RESP_OKAY;
        if (!in_range) begin
            beat_resp = RESP_DECERR;
        end else if (bad_burst || (cur_size > 3'd2)) begin
            beat_resp = RESP_SLVERR;
        end
    end

    // wlast must coincide exactly with beat == len; any mismatch is a protocol error.
    assign proto_err = io_slave_wlast ? (beat != cur_len) : (beat >= cur_len);
    // Encodings order naturally: DECERR(11) > SLVERR(10) > OKAY(00).
    assign w_resp    = (proto_err && (beat_resp < RESP_SLVERR)) ? RESP_SLVERR : beat_resp;

    assign aw_hs = io_slave_awvalid && io_slave_awready;
    assign ar_hs = io_slave_arvalid && io_slave_arready;
    assign w_hs  = io_slave_wvalid  && io_slave_wready;
    assign r_hs  = io_slave_rvalid  && io_slave_rready;
    assign b_hs  = io_slave_bvalid  && io_slave_bready;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and channel outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        io_slave_awready = 1'b0;
        io_slave_arready = 1'b0;
        io_slave_wready  = 1'b0;
        io_slave_bvalid  = 1'b0;
        io_slave_bresp   = 2'b00;
        io_slave_bid     = 4'd0;
        io_slave_rvalid  = 1'b0;
        io_slave_rresp   = 2'b00;
        io_slave_rdata   = 32'd0;
        io_slave_rlast   = 1'b0;
        io_slave_rid     = 4'd0;

        case (state_q)
            IDLE: begin
                // Readies are withheld during reset so nothing is accepted into a state being cleared.
                io_slave_awready = !reset;
                io_slave_arready = !reset && !io_slave_awvalid;
                if (!reset && io_slave_awvalid) begin
                    state_d = WR_DATA;
                end else if (!reset && io_slave_arvalid) begin
                    state_d = (RD_LAT > 1) ? RD_WAIT : RD_DATA;
                end
            end
            RD_WAIT: begin
                // Counter reaches 0 on the same edge the FSM enters RD_DATA.
                if (lat_cnt <= LAT_W'(1)) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                io_slave_rvalid = 1'b1;
                io_slave_rresp  = beat_resp;
                io_slave_rdata  = access_ok ? mem[word_idx] : 32'd0;
                io_slave_rlast  = (beat == cur_len);
                io_slave_rid    = cur_id;
                if (io_slave_rready && (beat == cur_len)) begin
                    state_d = IDLE;
                end
            end
            WR_DATA: begin
                io_slave_wready = !reset;
                if (!reset && io_slave_wvalid && io_slave_wlast) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                io_slave_bvalid = 1'b1;
                io_slave_bresp  = err;
                io_slave_bid    = cur_id;
                if (io_slave_bready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction context: latched command, beat counter, sticky write error
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_cnt   <= '0;
            cur_addr  <= 32'd0;
            cur_id    <= 4'd0;
            cur_len   <= 8'd0;
            cur_size  <= 3'd0;
            cur_burst <= 2'b00;
            beat      <= 8'd0;
            err       <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                cur_addr  <= io_slave_awaddr;
                cur_id    <= io_slave_awid;
                cur_len   <= io_slave_awlen;
                cur_size  <= io_slave_awsize;
                cur_burst <= io_slave_awburst;
                beat      <= 8'd0;
                err       <= RESP_OKAY;
            end else if (ar_hs) begin
                cur_addr  <= io_slave_araddr;
                cur_id    <= io_slave_arid;
                cur_len   <= io_slave_arlen;
                cur_size  <= io_slave_arsize;
                cur_burst <= io_slave_arburst;
                beat      <= 8'd0;
                err       <= RESP_OKAY;
                lat_cnt   <= LAT_INIT;
            end

            if (state_q == RD_WAIT) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end

            if (r_hs) begin
                beat     <= beat + 8'd1;
                cur_addr <= next_addr;
            end

            if (w_hs) begin
                // Saturate so an over-long burst can never wrap back onto beat == len.
                if (beat != 8'hFF) begin
                    beat <= beat + 8'd1;
                end
                cur_addr <= next_addr;
                if (w_resp > err) begin
                    err <= w_resp;
                end
            end

            if (b_hs) begin
                err <= RESP_OKAY;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: byte-strobed writes, dropped for out-of-range or WRAP/reserved bursts
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_hs && access_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (io_slave_wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= io_slave_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_axi_slave_mem.sv
// Self-checking bench for the AXI4 responder memory: table vectors, directed corner sequences, random traffic.
// Latency: bench drives one transaction at a time and waits on bounded handshakes.
// Backpressure: bench stalls rready per beat and delays nothing else.

module tb_ysyx_25040111_axi_slave_mem;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          DL2    = 8;
    localparam int          WORDS  = 1 << DL2;
    localparam int          RD_LAT = 3;

    logic        clock;
    logic        reset;
    logic        awready, awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wready, wvalid, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bready, bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arready, arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready, rvalid, rlast;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic [3:0]  rid;

    ysyx_25040111_axi_slave_mem #(
        .ADDR_BASE (BASE),
        .DEPTH_LOG2(DL2),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .io_slave_awready(awready),
        .io_slave_awvalid(awvalid),
        .io_slave_awaddr (awaddr),
        .io_slave_awid   (awid),
        .io_slave_awlen  (awlen),
        .io_slave_awsize (awsize),
        .io_slave_awburst(awburst),
        .io_slave_wready (wready),
        .io_slave_wvalid (wvalid),
        .io_slave_wdata  (wdata),
        .io_slave_wstrb  (wstrb),
        .io_slave_wlast  (wlast),
        .io_slave_bready (bready),
        .io_slave_bvalid (bvalid),
        .io_slave_bresp  (bresp),
        .io_slave_bid    (bid),
        .io_slave_arready(arready),
        .io_slave_arvalid(arvalid),
        .io_slave_araddr (araddr),
        .io_slave_arid   (arid),
        .io_slave_arlen  (arlen),
        .io_slave_arsize (arsize),
        .io_slave_arburst(arburst),
        .io_slave_rready (rready),
        .io_slave_rvalid (rvalid),
        .io_slave_rresp  (rresp),
        .io_slave_rdata  (rdata),
        .io_slave_rlast  (rlast),
        .io_slave_rid    (rid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [0:WORDS-1];
    logic [31:0] wdat    [0:255];
    logic [3:0]  wstb    [0:255];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake timed out", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench aborted");
    endtask

    // Reference rules: address of beat i, and the response that beat must carry.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst,
                                              input logic [2:0] size, input int i);
        return (burst == 2'b01) ? a + (32'(i) << size) : a;
    endfunction

    function automatic logic [1:0] ref_resp(input logic [31:0] a, input logic [1:0] burst,
                                            input logic [2:0] size);
        logic [31:0] o;
        o = a - BASE;
        if (o >= 32'(WORDS * 4)) return 2'b11;
        if (burst[1] || size > 3'd2) return 2'b10;
        return 2'b00;
    endfunction

    // Sends nbeats W beats from wdat/wstb with wlast on the final one.
    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input bit use_model, output logic [1:0] resp_o, output logic [3:0] bid_o);
        logic [1:0] exp_r, r;
        logic [31:0] a, o;
        logic rdy;
        int n;
        exp_r = 2'b00;
        for (int i = 0; i < nbeats; i++) begin
            a = beat_addr(addr, burst, size, i);
            r = ref_resp(a, burst, size);
            if ((i == nbeats - 1) != (i == int'(len)) || (i != nbeats - 1 && i > int'(len)))
                if (r < 2'b10) r = 2'b10;
            if (r > exp_r) exp_r = r;
            o = a - BASE;
            if (use_model && o < 32'(WORDS * 4) && !burst[1])
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) ref_mem[o[DL2+1:2]][8*b +: 8] = wdat[i][8*b +: 8];
        end

        awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst;
        n = 0;
        do begin
            @(negedge clock); rdy = awready;
            @(posedge clock); n++;
            if (!rdy && n > 64) tmo("aw handshake");
        end while (!rdy);
        #1 awvalid = 1'b0;

        for (int i = 0; i < nbeats; i++) begin
            wvalid = 1'b1; wdata = wdat[i]; wstrb = wstb[i]; wlast = (i == nbeats - 1);
            n = 0;
            do begin
                @(negedge clock); rdy = wready;
                @(posedge clock); n++;
                if (!rdy && n > 64) tmo("w handshake");
            end while (!rdy);
            #1;
        end
        wvalid = 1'b0; wlast = 1'b0;

        bready = 1'b1;
        n = 0;
        do begin
            @(negedge clock); rdy = bvalid; resp_o = bresp; bid_o = bid;
            @(posedge clock); n++;
            if (!rdy && n > 64) tmo("b handshake");
        end while (!rdy);
        #1 bready = 1'b0;
        if (use_model) begin
            chk("wr bresp", 32'(resp_o), 32'(exp_r));
            chk("wr bid", 32'(bid_o), 32'(id));
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int stall_beat,
                           input int stall_cycles, input bit rand_stall, input bit chk_lat,
                           input bit use_model, output logic [31:0] d0, output logic [1:0] r0,
                           output logic l0, output logic [3:0] id0);
        logic rdy;
        int n, edges, ns;
        logic [31:0] a, o, exp_d;
        logic [1:0] exp_r;
        arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
        n = 0;
        do begin
            @(negedge clock); rdy = arready;
            @(posedge clock); n++;
            if (!rdy && n > 64) tmo("ar handshake");
        end while (!rdy);
        #1 arvalid = 1'b0;
        edges = 1;
        while (!rvalid) begin
            @(posedge clock); #1;
            edges++;
            if (edges > 64) tmo("first rvalid");
        end
        if (chk_lat) chk("rd latency", 32'(edges), 32'(RD_LAT));

        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, burst, size, i);
            exp_r = ref_resp(a, burst, size);
            o = a - BASE;
            exp_d = (exp_r == 2'b11 || burst[1]) ? 32'd0 : ref_mem[o[DL2+1:2]];
            ns = (i == stall_beat) ? stall_cycles : (rand_stall ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s <= ns; s++) begin
                rready = (s == ns);
                if (i == 0) begin
                    d0 = rdata; r0 = rresp; l0 = rlast; id0 = rid;
                end
                chk("rd rvalid", 32'(rvalid), 32'd1);
                if (use_model) begin
                    chk("rd rdata", rdata, exp_d);
                    chk("rd rresp", 32'(rresp), 32'(exp_r));
                    chk("rd rlast", 32'(rlast), 32'(i == int'(len)));
                    chk("rd rid", 32'(rid), 32'(id));
                end
                @(posedge clock); #1;
            end
        end
        rready = 1'b0;
        chk("rd rvalid after last", 32'(rvalid), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wid;
        logic [3:0]  rid;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  eb;
        logic [1:0]  er;
        logic [31:0] ed;
    } vec_t;

    localparam int NV = 13;
    vec_t vec [NV];

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench aborted");
    end

    initial begin
        logic [1:0]  br, rr;
        logic [3:0]  bi, ri;
        logic [31:0] rd, a;
        logic        rl;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          nb;

        vec[0]  = '{1'b1, 32'h8000_0010, 4'd3,  4'd5,  3'd2, 2'b01, 32'hDEADBEEF, 4'hF, 2'b00, 2'b00, 32'hDEADBEEF};
        vec[1]  = '{1'b1, 32'h8000_0020, 4'd1,  4'd1,  3'd2, 2'b01, 32'h11223344, 4'hF, 2'b00, 2'b00, 32'h11223344};
        vec[2]  = '{1'b1, 32'h8000_0020, 4'd2,  4'd2,  3'd2, 2'b01, 32'hAABBCCDD, 4'h5, 2'b00, 2'b00, 32'h11BB33DD};
        vec[3]  = '{1'b1, 32'h8000_0400, 4'd4,  4'd4,  3'd2, 2'b01, 32'h12345678, 4'hF, 2'b11, 2'b11, 32'h0};
        vec[4]  = '{1'b1, 32'h7FFF_FFFC, 4'd5,  4'd6,  3'd2, 2'b01, 32'h12345678, 4'hF, 2'b11, 2'b11, 32'h0};
        vec[5]  = '{1'b1, 32'h8000_0044, 4'd6,  4'd7,  3'd2, 2'b00, 32'hCAFEF00D, 4'hF, 2'b00, 2'b00, 32'hCAFEF00D};
        vec[6]  = '{1'b1, 32'h8000_0044, 4'd7,  4'd8,  3'd2, 2'b10, 32'h00000000, 4'hF, 2'b10, 2'b10, 32'h0};
        vec[7]  = '{1'b0, 32'h8000_0044, 4'd0,  4'd9,  3'd2, 2'b01, 32'h0,        4'h0, 2'b00, 2'b00, 32'hCAFEF00D};
        vec[8]  = '{1'b1, 32'h8000_0050, 4'd1,  4'd2,  3'd2, 2'b01, 32'h01020304, 4'hF, 2'b00, 2'b00, 32'h01020304};
        vec[9]  = '{1'b1, 32'h8000_0051, 4'd3,  4'd4,  3'd0, 2'b01, 32'hFFFFABFF, 4'h2, 2'b00, 2'b00, 32'h0102AB04};
        vec[10] = '{1'b1, 32'h8000_03FC, 4'd8,  4'd9,  3'd2, 2'b01, 32'h0BADCAFE, 4'hF, 2'b00, 2'b00, 32'h0BADCAFE};
        vec[11] = '{1'b1, 32'h8000_0030, 4'd10, 4'd11, 3'd3, 2'b01, 32'h12345678, 4'hF, 2'b10, 2'b10, 32'h12345678};
        vec[12] = '{1'b1, 32'h8000_0038, 4'd12, 4'd13, 3'd2, 2'b11, 32'h87654321, 4'hF, 2'b10, 2'b10, 32'h0};

        reset = 1'b1;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset rvalid", 32'(rvalid), 32'd0);
        chk("reset bvalid", 32'(bvalid), 32'd0);
        chk("reset rlast", 32'(rlast), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset ids", {24'd0, rid, bid}, 32'd0);
        chk("reset resps", {28'd0, rresp, bresp}, 32'd0);
        chk("reset wready", 32'(wready), 32'd0);
        reset = 1'b0;
        #1;
        chk("idle awready", 32'(awready), 32'd1);
        chk("idle arready", 32'(arready), 32'd1);

        // Single-beat write/read vectors on a fresh array.
        for (int i = 0; i < NV; i++) begin
            if (vec[i].wr) begin
                wdat[0] = vec[i].wdata;
                wstb[0] = vec[i].wstrb;
                do_write(vec[i].addr, vec[i].wid, 8'd0, vec[i].size, vec[i].burst, 1, 1'b0, br, bi);
                chk($sformatf("vec%0d bresp", i), 32'(br), 32'(vec[i].eb));
                chk($sformatf("vec%0d bid", i), 32'(bi), 32'(vec[i].wid));
            end
            do_read(vec[i].addr, vec[i].rid, 8'd0, vec[i].size, vec[i].burst, -1, 0, 1'b0, 1'b0, 1'b0,
                    rd, rr, rl, ri);
            chk($sformatf("vec%0d rdata", i), rd, vec[i].ed);
            chk($sformatf("vec%0d rresp", i), 32'(rr), 32'(vec[i].er));
            chk($sformatf("vec%0d rlast", i), 32'(rl), 32'd1);
            chk($sformatf("vec%0d rid", i), 32'(ri), 32'(vec[i].rid));
        end

        // Fill the whole array so the model knows every word.
        for (int i = 0; i < WORDS; i++) begin
            wdat[i] = $urandom;
            wstb[i] = 4'hF;
        end
        do_write(BASE, 4'd0, 8'(WORDS - 1), 3'd2, 2'b01, WORDS, 1'b1, br, bi);

        // Latency and stall: words 0..3, beat 1 held off for two cycles.
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'(i);
            wstb[i] = 4'hF;
        end
        do_write(BASE, 4'd1, 8'd3, 3'd2, 2'b01, 4, 1'b1, br, bi);
        do_read(BASE, 4'd2, 8'd3, 3'd2, 2'b01, 1, 2, 1'b0, 1'b1, 1'b1, rd, rr, rl, ri);
        chk("lat burst beat0 data", rd, 32'd0);

        // Burst crossing from below the window into word 0.
        do_read(32'h7FFF_FFFC, 4'd3, 8'd1, 3'd2, 2'b01, -1, 0, 1'b0, 1'b0, 1'b1, rd, rr, rl, ri);
        chk("cross beat0 rresp", 32'(rr), 32'b11);

        // wlast early, and an extra beat past len.
        wdat[0] = 32'h1; wdat[1] = 32'h2; wstb[0] = 4'hF; wstb[1] = 4'hF;
        do_write(BASE + 32'h100, 4'd6, 8'd3, 3'd2, 2'b01, 2, 1'b1, br, bi);
        chk("early wlast bresp", 32'(br), 32'b10);
        do_write(BASE + 32'h110, 4'd7, 8'd0, 3'd2, 2'b01, 2, 1'b1, br, bi);
        chk("late wlast bresp", 32'(br), 32'b10);
        do_read(BASE + 32'h110, 4'd8, 8'd1, 3'd2, 2'b01, -1, 0, 1'b0, 1'b0, 1'b1, rd, rr, rl, ri);

        // Simultaneous AR and AW: write wins, read waits until the B handshake.
        awvalid = 1'b1; awaddr = BASE + 32'h60; awid = 4'd2; awlen = 0; awsize = 3'd2; awburst = 2'b01;
        arvalid = 1'b1; araddr = BASE + 32'h60; arid = 4'd7; arlen = 0; arsize = 3'd2; arburst = 2'b01;
        @(negedge clock);
        chk("race awready", 32'(awready), 32'd1);
        chk("race arready", 32'(arready), 32'd0);
        @(posedge clock); #1;
        awvalid = 1'b0;
        chk("race arready in wr", 32'(arready), 32'd0);
        wvalid = 1'b1; wdata = 32'h5A5A1234; wstrb = 4'hF; wlast = 1'b1;
        @(negedge clock);
        chk("race wready", 32'(wready), 32'd1);
        @(posedge clock); #1;
        wvalid = 1'b0; wlast = 1'b0;
        ref_mem[24] = 32'h5A5A1234;
        chk("race bvalid", 32'(bvalid), 32'd1);
        chk("race bid", 32'(bid), 32'd2);
        chk("race bresp", 32'(bresp), 32'd0);
        chk("race arready in resp", 32'(arready), 32'd0);
        bready = 1'b1;
        @(posedge clock); #1;
        bready = 1'b0;
        chk("race arready after b", 32'(arready), 32'd1);
        do_read(BASE + 32'h60, 4'd7, 8'd0, 3'd2, 2'b01, -1, 0, 1'b0, 1'b0, 1'b1, rd, rr, rl, ri);
        chk("race read data", rd, 32'h5A5A1234);

        // Reset during beat 2 of a 4-beat read.
        arvalid = 1'b1; araddr = BASE; arid = 4'd9; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
        nb = 0;
        do begin
            @(posedge clock); #1; nb++;
            if (nb > 64) tmo("reset test ar");
        end while (!(arvalid && !arready && !rvalid && nb > 1) && !rvalid);
        arvalid = 1'b0;
        nb = 0;
        while (!rvalid) begin
            @(posedge clock); #1; nb++;
            if (nb > 64) tmo("reset test rvalid");
        end
        rready = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        rready = 1'b0;
        chk("abort beat2 data", rdata, ref_mem[2]);
        chk("abort beat2 rlast", 32'(rlast), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort rvalid", 32'(rvalid), 32'd0);
        chk("abort rlast", 32'(rlast), 32'd0);
        chk("abort rdata", rdata, 32'd0);
        chk("abort rid", 32'(rid), 32'd0);
        reset = 1'b0;
        #1;
        chk("abort awready", 32'(awready), 32'd1);
        chk("abort arready", 32'(arready), 32'd1);
        do_read(BASE + 32'h8, 4'd4, 8'd0, 3'd2, 2'b01, -1, 0, 1'b0, 1'b1, 1'b1, rd, rr, rl, ri);

        // Random traffic against the reference array.
        for (int t = 0; t < 80; t++) begin
            a     = BASE - 32'd16 + 32'($urandom_range(0, 1056));
            len   = 8'($urandom_range(0, 7));
            size  = 3'($urandom_range(0, 3));
            burst = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                nb = int'(len) + 1 + (($urandom_range(0, 9) == 0) ? 1 : 0);
                for (int i = 0; i < nb; i++) begin
                    wdat[i] = $urandom;
                    wstb[i] = 4'($urandom);
                end
                do_write(a, 4'($urandom), len, size, burst, nb, 1'b1, br, bi);
            end else begin
                do_read(a, 4'($urandom), len, size, burst, -1, 0, 1'b1, 1'b1, 1'b1, rd, rr, rl, ri);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
